// File: rtl/uart_pixel_receiver.sv
// UART receiver that pairs consecutive bytes into 16-bit pixel words.
// Oversampled start/data/stop FSM with a 2-flop line synchronizer.
module uart_pixel_receiver #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        serialIn,
  output logic [15:0] pixelData,
  output logic        pixelValid,
  output logic        frameErr,
  output logic        busy
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nxt;
  logic                 w_shift_en;
  logic                 w_stop_en;
  logic [1:0]           r_sync;
  logic                 w_rx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hi;
  logic                 r_phase_lsb;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], serialIn};
    end
  end

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_en  = 1'b0;
    w_stop_en   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          w_bit_nxt  = r_bit + 1'b1;
          if (r_bit == BIT_LAST) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt   = '0;
          w_stop_en   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // A bad stop bit drops any held high byte so the next pair realigns.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_shift     <= '0;
      r_hi        <= '0;
      r_phase_lsb <= 1'b0;
      pixelData   <= '0;
      pixelValid  <= 1'b0;
      frameErr    <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      frameErr   <= 1'b0;
      if (w_shift_en) begin
        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
      end
      if (w_stop_en) begin
        if (w_rx) begin
          if (!r_phase_lsb) begin
            r_hi        <= r_shift;
            r_phase_lsb <= 1'b1;
          end else begin
            pixelData   <= 16'({r_hi, r_shift});
            pixelValid  <= 1'b1;
            r_phase_lsb <= 1'b0;
          end
        end else begin
          frameErr    <= 1'b1;
          r_hi        <= '0;
          r_phase_lsb <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_receiver.sv
// Directed bench for uart_pixel_receiver at 16 samples per bit.
// Pixel strobes are collected at negedge and checked per scenario.
module tb_uart_pixel_receiver;

  logic        clk;
  logic        nRST;
  logic        serialIn;
  logic [15:0] pixelData;
  logic        pixelValid;
  logic        frameErr;
  logic        busy;

  int          n_chk;
  int          n_fail;
  int          cyc;
  int          n_ferr;
  int          r_vcyc;
  logic [15:0] err_pix;
  logic [15:0] q_pix[$];
  logic [15:0] q_exp[$];

  uart_pixel_receiver #(
    .SAMPLES_PER_BIT(16),
    .DATA_BITS(8)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .serialIn  (serialIn),
    .pixelData (pixelData),
    .pixelValid(pixelValid),
    .frameErr  (frameErr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_ferr = 0;
    r_vcyc = 0;
    err_pix = '0;
  end

  always @(negedge clk) begin
    if (nRST) begin
      if (pixelValid) begin
        q_pix.push_back(pixelData);
        r_vcyc = cyc;
      end
      if (frameErr) begin
        n_ferr++;
        err_pix = pixelData;
      end
      if (pixelValid || frameErr)
        check("excl", {31'b0, pixelValid & frameErr}, 32'd0);
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serialIn = f[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_frame(w[15:8], 1'b1);
    send_frame(w[7:0], 1'b1);
  endtask

  task automatic idle(input int n);
    serialIn = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic verify_pix(input string tag);
    int n;
    check({tag, "_n"}, q_pix.size(), q_exp.size());
    n = (q_pix.size() < q_exp.size()) ? q_pix.size() : q_exp.size();
    for (int i = 0; i < n; i++) check(tag, q_pix[i], q_exp[i]);
    q_pix.delete();
    q_exp.delete();
  endtask

  int t0;
  int e0;
  logic [9:0] fr;

  initial begin
    n_chk = 0;
    n_fail = 0;
    nRST = 1'b0;
    serialIn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pix", pixelData, 16'h0000);
    check("rst_valid", pixelValid, 1'b0);
    check("rst_err", frameErr, 1'b0);
    check("rst_busy", busy, 1'b0);
    nRST = 1'b1;
    idle(10);
    check("idle_busy", busy, 1'b0);

    send_frame(8'hAB, 1'b1);
    t0 = cyc;
    send_frame(8'hCD, 1'b1);
    idle(20);
    q_exp.push_back(16'hABCD);
    check("abcd_when", r_vcyc - t0, 155);
    verify_pix("abcd");

    send_word(16'hFFFF);
    send_word(16'hAAAA);
    send_word(16'h0001);
    idle(20);
    q_exp.push_back(16'hFFFF);
    q_exp.push_back(16'hAAAA);
    q_exp.push_back(16'h0001);
    verify_pix("b2b");

    e0 = n_ferr;
    serialIn = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_hi", busy, 1'b1);
    repeat (2) @(negedge clk);
    serialIn = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_busy_lo", busy, 1'b0);
    idle(20);
    check("glitch_err", n_ferr - e0, 0);
    verify_pix("glitch");
    send_word(16'h1234);
    idle(20);
    q_exp.push_back(16'h1234);
    verify_pix("post_glitch");

    e0 = n_ferr;
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b0);
    idle(32);
    check("ferr_cnt", n_ferr - e0, 1);
    check("ferr_pix_hold", err_pix, 16'h1234);
    verify_pix("ferr_none");
    send_word(16'h7788);
    idle(20);
    q_exp.push_back(16'h7788);
    verify_pix("resync");

    e0 = n_ferr;
    for (int i = 0; i < 16; i++) begin
      send_word(16'(i));
      q_exp.push_back(16'(i));
    end
    idle(20);
    verify_pix("loop");
    check("loop_err", n_ferr - e0, 0);

    e0 = n_ferr;
    serialIn = 1'b0;
    repeat (320) @(negedge clk);
    idle(200);
    check("break_err", n_ferr - e0, 2);
    verify_pix("break");
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    idle(20);

    send_frame(8'hBE, 1'b1);
    fr = {1'b1, 8'hEF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      serialIn = fr[i];
      repeat (16) @(negedge clk);
    end
    serialIn = fr[5];
    repeat (8) @(negedge clk);
    nRST = 1'b0;
    serialIn = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_pix", pixelData, 16'h0000);
    check("abort_valid", pixelValid, 1'b0);
    nRST = 1'b1;
    idle(200);
    check("abort_idle", busy, 1'b0);
    verify_pix("abort");
    send_word(16'hCAFE);
    idle(20);
    q_exp.push_back(16'hCAFE);
    verify_pix("cafe");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pixel_receiver.md
UART_PIXEL_RECEIVER -- requirements
Module: uart_pixel_receiver

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 16, clk cycles per serial bit period; legal values are even numbers of 4 or more.
REQ-002 Parameter DATA_BITS, default 8, data bits per serial frame.
REQ-003 Port clk  input  1  oversample clock; all flops rise on its positive edge; single clock domain.
REQ-004 Port nRST  input  1  reset; asynchronous assert, active-low.
REQ-005 Port serialIn  input  1  asynchronous serial line; idles high.
REQ-006 Port pixelData  output  16  last completed pixel word; first received byte forms [15:8], second byte forms [7:0].
REQ-007 Port pixelValid  output  1  one-cycle strobe; pixelData is new in the same cycle.
REQ-008 Port frameErr  output  1  one-cycle strobe on a bad stop bit.
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 serialIn SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rxS).
REQ-011 The FSM SHALL have the states IDLE, START, DATA and STOP, plus a sample counter cnt and a bit counter bitIdx.
REQ-012 IDLE: when rxS==0, go to START with cnt=0.
REQ-013 START: at cnt==SAMPLES_PER_BIT/2-1, if rxS==0 go to DATA with cnt=0 and bitIdx=0; otherwise the event is a glitch, so return to IDLE with no strobe.
REQ-014 DATA: sample rxS at cnt==SAMPLES_PER_BIT-1 (mid-bit), shift it into the byte register LSB-first, and clear cnt; after DATA_BITS samples, go to STOP.
REQ-015 STOP: sample at cnt==SAMPLES_PER_BIT-1, then go to IDLE in the following cycle.
REQ-016 Stop sample ==1 means a good byte: if the byte phase is MSB, latch it into hiByte and set the phase to LSB; if the phase is LSB, load pixelData={hiByte,byte}, pulse pixelValid, and set the phase to MSB.
REQ-017 Stop sample ==0 means a framing error: pulse frameErr, discard the byte and any held hiByte, and force the phase to MSB; pixelData SHALL be unchanged.
REQ-018 pixelValid and frameErr SHALL assert in the cycle after the stop-bit sample edge, for exactly one cycle, and never both in the same cycle.
REQ-019 After a stop sample, a new start edge SHALL be accepted on the first cycle back in IDLE (line low), which supports back-to-back frames.
REQ-020 A line held low through IDLE (break) SHALL re-enter START each time; every resulting frame ends in frameErr, with no pixelValid.
REQ-021 Counters SHALL be sized as $clog2(SAMPLES_PER_BIT) and $clog2(DATA_BITS+1) bits; cnt SHALL never wrap past SAMPLES_PER_BIT-1.
REQ-022 The module SHALL contain no combinational path from serialIn to any output.

Reset
REQ-023 When nRST is low: state=IDLE, cnt=0, bitIdx=0, byte phase=MSB, hiByte=8'h00, pixelData=16'h0000, pixelValid=0, frameErr=0, busy=0, and synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with no strobe; after release, reception SHALL resume only on a fresh falling edge.
REQ-025 Outputs SHALL hold their reset values until the first complete frame.

Verification
REQ-026 Two frames 8'hAB then 8'hCD, SAMPLES_PER_BIT=16, 10-bit frames -> one pixelValid with pixelData=16'hABCD, in the cycle after the second stop sample.
REQ-027 Back-to-back words 16'hFFFF, 16'hAAAA, 16'h0001 with no idle gap -> three pixelValid strobes carrying exactly those values, in order.
REQ-028 Low pulse of 6 clk cycles on an idle line -> no strobe, busy returns low at cycle 8, and the next valid pair 8'h12, 8'h34 yields 16'h1234.
REQ-029 Byte 8'h55 followed by a frame 8'h66 whose stop bit is 0, then bytes 8'h77, 8'h88 -> one frameErr and no pixelValid for the bad pair, then pixelValid with 16'h7788 (the MSB phase was resynced).
REQ-030 nRST pulsed low during bit 4 of the second byte of 16'hBEEF, then the word 16'hCAFE sent -> no strobe for BEEF, and pixelValid with 16'hCAFE.
REQ-031 Loop from the transmitter-side path (16 incrementing pixel words 16'h0000 to 16'h000F) -> 16 pixelValid strobes matching the sent values, with zero frameErr.
